bcd_xs3_serial_sequencer: RTL and testbench

//  Shares one bit-serial BCD->Excess-3 Mealy converter between two requesters.

---
 rtl/bcd_xs3_serial_sequencer_if.sv | 37 +++
 rtl/bcd_xs3_serial_sequencer.sv | 113 +++++++++++
 tb/tb_bcd_xs3_serial_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_xs3_serial_sequencer_if.sv
// Handshake bundle for the shared BCD to Excess-3 serial sequencer.
// Covers both requester ports, the response port and the converter link.
interface bcd_xs3_serial_sequencer_if #(
   parameter int DIGITS = 4
);
   localparam int W = 4 * DIGITS;

   logic         req0_valid;
   logic [W-1:0] req0_data;
   logic         req0_ready;
   logic         req1_valid;
   logic [W-1:0] req1_data;
   logic         req1_ready;
   logic         conv_x;
   logic         conv_rst_n;
   logic         conv_z;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_id;
   logic         rsp_err;
   logic         busy;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data,
      output conv_z, rsp_ready,
      input  req0_ready, req1_ready, conv_x, conv_rst_n,
      input  rsp_valid, rsp_data, rsp_id, rsp_err, busy
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data,
      input  conv_z, rsp_ready,
      output req0_ready, req1_ready, conv_x, conv_rst_n,
      output rsp_valid, rsp_data, rsp_id, rsp_err, busy
   );
endinterface

// File: rtl/bcd_xs3_serial_sequencer.sv
// Round-robin front end sharing one bit-serial BCD to Excess-3 converter.
// Words stream LSB-first through the converter and return as parallel words.
module bcd_xs3_serial_sequencer #(
   parameter int DIGITS = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   bcd_xs3_serial_sequencer_if.slave bus
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, CLR, SHIFT, RESP} state_e;

   state_e        state_q, state_d;
   logic          rr_q;
   logic          id_q;
   logic          err_q;
   logic [W-1:0]  word_q;
   logic [W-1:0]  res_q;
   logic [CW-1:0] cnt_q;

   logic          gnt0, gnt1, acc, acc_id, acc_bad;
   logic [W-1:0]  acc_data;

   function automatic logic has_bad_digit(input logic [W-1:0] w);
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (w[4*k +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // rr_q==0 prefers requester 0 when both are asking
   always_comb begin
      gnt0 = (state_q == IDLE) && bus.req0_valid &&
             (!bus.req1_valid || !rr_q);
      gnt1 = (state_q == IDLE) && bus.req1_valid &&
             (!bus.req0_valid || rr_q);
      acc      = gnt0 || gnt1;
      acc_id   = gnt1;
      acc_data = gnt1 ? bus.req1_data : bus.req0_data;
      acc_bad  = has_bad_digit(acc_data);
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (acc) state_d = acc_bad ? RESP : CLR;
         CLR:   state_d = SHIFT;
         SHIFT: if (cnt_q == CW'(W - 1)) state_d = RESP;
         RESP:  if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_q   <= 1'b0;
         id_q   <= 1'b0;
         err_q  <= 1'b0;
         word_q <= '0;
         res_q  <= '0;
         cnt_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (acc) begin
                  word_q <= acc_data;
                  id_q   <= acc_id;
                  rr_q   <= ~acc_id;
                  err_q  <= acc_bad;
                  res_q  <= '0;
               end
            end
            CLR: cnt_q <= '0;
            SHIFT: begin
               // result fills from the top so bit 0 lands last in place
               word_q <= {1'b0, word_q[W-1:1]};
               res_q  <= {bus.conv_z, res_q[W-1:1]};
               cnt_q  <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.req0_ready = gnt0;
      bus.req1_ready = gnt1;
      bus.conv_x     = 1'b0;
      bus.conv_rst_n = 1'b0;
      bus.rsp_valid  = 1'b0;
      bus.busy       = (state_q != IDLE);
      bus.rsp_data   = res_q;
      bus.rsp_id     = id_q;
      bus.rsp_err    = err_q;
      unique case (state_q)
         SHIFT: begin
            bus.conv_x     = word_q[0];
            bus.conv_rst_n = 1'b1;
         end
         RESP: bus.rsp_valid = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_bcd_xs3_serial_sequencer.sv
// Directed bench for the shared BCD to Excess-3 serial sequencer.
// Includes a behavioural Mealy converter on the serial link.
module tb_bcd_xs3_serial_sequencer;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   bcd_xs3_serial_sequencer_if #(.DIGITS(4)) bus();

   bcd_xs3_serial_sequencer #(.DIGITS(4)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   // converter: adds 0011 per digit, carry chain restarts each digit
   logic [1:0] cpos = 2'd0;
   logic       ccar = 1'b0;
   logic       cadd;
   assign cadd = ~cpos[1];
   assign bus.conv_z = bus.conv_x ^ cadd ^ ccar;

   always @(posedge clk) begin
      if (!bus.conv_rst_n) begin
         cpos <= 2'd0;
         ccar <= 1'b0;
      end else begin
         cpos <= cpos + 2'd1;
         ccar <= (cpos == 2'd3) ? 1'b0 :
                 ((bus.conv_x & cadd) | (bus.conv_x & ccar) | (cadd & ccar));
      end
   end

   bit both_hi  = 1'b0;
   bit crn_seen = 1'b0;

   always @(posedge clk) begin
      if (bus.req0_ready && bus.req1_ready) both_hi = 1'b1;
      if (bus.conv_rst_n) crn_seen = 1'b1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // present a word, wait for grant, pass accept edge E0, drop valid
   task automatic accept(input bit id, input logic [15:0] d);
      int t;
      @(negedge clk);
      if (id) begin
         bus.req1_data  = d;
         bus.req1_valid = 1'b1;
      end else begin
         bus.req0_data  = d;
         bus.req0_valid = 1'b1;
      end
      #1;
      t = 0;
      while (!(id ? bus.req1_ready : bus.req0_ready) && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("grant", {31'd0, id ? bus.req1_ready : bus.req0_ready}, 1);
      @(posedge clk);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_data  = 16'($urandom);
      bus.req1_data  = 16'($urandom);
   endtask

   // count edges after E0 until rsp_valid is seen
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!bus.rsp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_word(input bit id, input logic [15:0] d,
                          input logic [15:0] exp_d, input bit exp_err,
                          input int exp_lat);
      int lat;
      accept(id, d);
      wait_rsp(lat);
      check("latency", lat, exp_lat);
      check("rsp_data", {16'd0, bus.rsp_data}, {16'd0, exp_d});
      check("rsp_id", {31'd0, bus.rsp_id}, {31'd0, id});
      check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
      @(posedge clk);
      @(negedge clk);
      check("idle_after", {31'd0, bus.busy}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ng;
      int nr;
      logic [3:0]  gseq;
      logic [15:0] rd [4];
      logic        rid [4];
      bit          stable;

      rst            = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_data  = '0;
      bus.req1_data  = '0;
      bus.rsp_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctl", {26'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
                        bus.busy, bus.conv_x, bus.conv_rst_n}, 0);
      check("rst_data", {16'd0, bus.rsp_data}, 0);
      rst = 1'b0;

      // both requesters held valid from reset
      @(negedge clk);
      bus.rsp_ready  = 1'b1;
      bus.req0_data  = 16'h0001;
      bus.req1_data  = 16'h0002;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      ng   = 0;
      nr   = 0;
      gseq = '0;
      for (int cyc = 0; cyc < 300 && nr < 4; cyc++) begin
         #1;
         if (ng < 4 && bus.req0_ready) begin
            gseq[ng] = 1'b0;
            ng++;
         end else if (ng < 4 && bus.req1_ready) begin
            gseq[ng] = 1'b1;
            ng++;
         end
         if (bus.rsp_valid) begin
            rd[nr]  = bus.rsp_data;
            rid[nr] = bus.rsp_id;
            nr++;
            if (nr == 4) begin
               bus.req0_valid = 1'b0;
               bus.req1_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      check("rr_ngrant", ng, 4);
      check("rr_nrsp", nr, 4);
      check("rr_order", {28'd0, gseq}, 32'b1010);
      check("rr_rsp0", {15'd0, rid[0], rd[0]}, {15'd0, 1'b0, 16'h3334});
      check("rr_rsp1", {15'd0, rid[1], rd[1]}, {15'd0, 1'b1, 16'h3335});
      check("rr_one_ready", {31'd0, both_hi}, 0);
      @(negedge clk);

      do_word(1'b0, 16'h1234, 16'h4567, 1'b0, 17);
      do_word(1'b1, 16'h9999, 16'hCCCC, 1'b0, 17);
      do_word(1'b0, 16'h0000, 16'h3333, 1'b0, 17);
      do_word(1'b0, 16'h9050, 16'hC383, 1'b0, 17);

      // bad digit answers straight after the accept edge
      crn_seen = 1'b0;
      do_word(1'b1, 16'h12A4, 16'h0000, 1'b1, 0);
      check("err_no_conv", {31'd0, crn_seen}, 0);

      // response backpressure
      bus.rsp_ready = 1'b0;
      accept(1'b0, 16'h0789);
      begin
         int lat;
         wait_rsp(lat);
         check("bp_latency", lat, 17);
      end
      bus.req1_data  = 16'h0001;
      bus.req1_valid = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (bus.rsp_data !== 16'h3ABC || bus.rsp_id !== 1'b0 ||
             bus.rsp_err !== 1'b0 || bus.rsp_valid !== 1'b1 ||
             bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
            stable = 1'b0;
         @(negedge clk);
      end
      check("bp_stable", {31'd0, stable}, 1);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("bp_release", {30'd0, bus.busy, bus.req1_ready}, 32'b01);
      bus.req1_valid = 1'b0;

      // reset in the 7th SHIFT cycle
      accept(1'b0, 16'h0001);
      repeat (7) @(negedge clk);
      check("mid_shift", {30'd0, bus.busy, bus.conv_rst_n}, 32'b11);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst", {29'd0, bus.busy, bus.rsp_valid, bus.conv_rst_n}, 0);
      rst = 1'b0;
      do_word(1'b0, 16'h0456, 16'h3789, 1'b0, 17);
      check("one_ready_end", {31'd0, both_hi}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
